// File: rtl/pce_rom_loader.sv
// rtl/pce_rom_loader.sv - HPS ROM download bridge feeding the DDR3 and SDRAM writers
// One toggle request per word; the HPS is held off until both writers echo it back.
module pce_rom_loader #(
  parameter int          ADDR_W   = 24,
  parameter logic [19:0] SIG_BLK0 = 20'h1F2,
  parameter logic [19:0] SIG_BLK1 = 20'h212
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [15:0]       dl_data,
  input  logic              swap_en,
  output logic              dl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_req,
  input  logic              dd_ack,
  input  logic              sd_ack,
  output logic [7:0]        rom_size,
  output logic              hdr_present,
  output logic              populous,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WAIT_ACK,
    S_FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic              act_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              req_q, req_d;
  logic              wait_q, wait_d;
  logic [1:0]        pop_q, pop_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              act_rise;
  logic              act_fall;
  logic              ack_match;
  logic              last_addr;
  logic [15:0]       word_sw;
  logic              sig_blk;
  logic              sig_chk;
  logic [15:0]       sig_exp;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  assign act_rise  = dl_active & ~act_q;
  assign act_fall  = ~dl_active & act_q;
  assign ack_match = (req_q == dd_ack) && (req_q == sd_ack);
  assign last_addr = (addr_q == {{(ADDR_W-1){1'b1}}, 1'b0});
  assign word_sw   = swap_en ? {rev8(dl_data[15:8]), rev8(dl_data[7:0])} : dl_data;
  assign sig_blk   = (addr_q[23:4] == SIG_BLK0) || (addr_q[23:4] == SIG_BLK1);

  // "POPULOUS" spread over words at offsets 6..12 of the signature block
  always_comb begin
    sig_chk = 1'b1;
    sig_exp = 16'h0000;
    case (addr_q[3:0])
      4'h6:    sig_exp = 16'h4F50;
      4'h8:    sig_exp = 16'h5550;
      4'hA:    sig_exp = 16'h4F4C;
      4'hC:    sig_exp = 16'h5355;
      default: sig_chk = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      act_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      req_q   <= 1'b0;
      wait_q  <= 1'b0;
      pop_q   <= 2'b11;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= dl_active;
      addr_q  <= addr_d;
      data_q  <= data_d;
      req_q   <= req_d;
      wait_q  <= wait_d;
      pop_q   <= pop_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (act_rise) state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (dl_wr) begin
          if (!ovf_q) state_d = S_WAIT_ACK;
        end else if (act_fall) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_ACK: begin
        if (ack_match) state_d = dl_active ? S_ACCEPT : S_FLUSH;
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    req_d  = req_q;
    wait_d = wait_q;
    pop_d  = pop_q;
    done_d = 1'b0;
    ovf_d  = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (act_rise) begin
          addr_d = '0;
          pop_d  = 2'b11;
          ovf_d  = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (dl_wr) begin
          // Once the address space is exhausted, words are silently dropped
          if (!ovf_q) begin
            data_d = word_sw;
            req_d  = ~req_q;
            wait_d = 1'b1;
            if (sig_blk && sig_chk && (word_sw != sig_exp)) pop_d[addr_q[13]] = 1'b0;
          end
        end else if (act_fall) begin
          done_d = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (ack_match) begin
          wait_d = 1'b0;
          if (last_addr) ovf_d = 1'b1;
          else addr_d = addr_q + ADDR_W'(2);
          if (!dl_active) done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign dl_wait     = wait_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign mem_req     = req_q;
  assign rom_size    = addr_q[23:16];
  assign hdr_present = addr_q[9];
  assign populous    = pop_q[addr_q[9]];
  assign done        = done_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_pce_rom_loader.sv
// tb/tb_pce_rom_loader.sv - self-checking bench for pce_rom_loader
// Acks are echoed by two independent delay models; expectations come from a word-level image model.
module tb_pce_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl_active;
  logic        dl_wr;
  logic [15:0] dl_data;
  logic        swap_en;
  logic        dl_wait;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_req;
  logic        dd_ack;
  logic        sd_ack;
  logic [7:0]  rom_size;
  logic        hdr_present;
  logic        populous;
  logic        done;
  logic        overflow;

  int pass_cnt  = 0;
  int check_cnt = 0;

  bit ack_clr;
  bit ack_hold;
  int dd_dly;
  int sd_dly;
  int dd_cnt;
  int sd_cnt;
  int done_total = 0;
  int done_base;

  logic [23:0] m_addr;
  logic [15:0] m_data;
  logic        m_req;
  bit          m_ovf;
  logic [15:0] m_mem [int];

  localparam logic [63:0] SIGS = {16'h4F50, 16'h5550, 16'h4F4C, 16'h5355};

  pce_rom_loader dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_data     (dl_data),
    .swap_en     (swap_en),
    .dl_wait     (dl_wait),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_req     (mem_req),
    .dd_ack      (dd_ack),
    .sd_ack      (sd_ack),
    .rom_size    (rom_size),
    .hdr_present (hdr_present),
    .populous    (populous),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (ack_clr) begin
      dd_ack = 1'b0;
      sd_ack = 1'b0;
      dd_cnt = 0;
      sd_cnt = 0;
    end else if (!ack_hold) begin
      if (mem_req !== dd_ack) begin
        dd_cnt++;
        if (dd_cnt >= dd_dly) begin dd_ack = mem_req; dd_cnt = 0; end
      end else dd_cnt = 0;
      if (mem_req !== sd_ack) begin
        sd_cnt++;
        if (sd_cnt >= sd_dly) begin sd_ack = mem_req; sd_cnt = 0; end
      end else sd_cnt = 0;
    end
  end

  always @(negedge clk_sys) if (done === 1'b1) done_total++;

  function automatic logic [15:0] swapw(input logic [15:0] d, input bit sw);
    logic [15:0] r;
    r = d;
    if (sw) for (int i = 0; i < 16; i++) r[(i & 8) | (7 - (i & 7))] = d[i];
    return r;
  endfunction

  function automatic bit model_pop(input bit h);
    int          base;
    logic [63:0] s;
    bit          ok;
    base = h ? 'h2120 : 'h1F20;
    s    = SIGS;
    ok   = 1'b1;
    for (int k = 0; k < 4; k++)
      if (m_mem.exists(base + 6 + 2 * k) && (m_mem[base + 6 + 2 * k] !== s[63 - 16 * k -: 16])) ok = 1'b0;
    return ok;
  endfunction

  task automatic start_dl(input bit with_wr);
    dl_active = 1'b1;
    dl_wr     = with_wr;
    dl_data   = 16'hBEEF;
    @(negedge clk_sys);
    dl_wr     = 1'b0;
    m_addr    = 24'h0;
    m_ovf     = 1'b0;
    m_mem.delete();
    done_base = done_total;
    check_cnt++; if (mem_addr !== 24'h0) $display("FAIL start_addr: got %h exp 000000", mem_addr); else pass_cnt++;
    check_cnt++; if (overflow !== 1'b0) $display("FAIL start_ovf: got %b exp 0", overflow); else pass_cnt++;
    check_cnt++; if (mem_req !== m_req) $display("FAIL start_req: got %b exp %b", mem_req, m_req); else pass_cnt++;
    check_cnt++; if (dl_wait !== 1'b0) $display("FAIL start_wait: got %b exp 0", dl_wait); else pass_cnt++;
  endtask

  task automatic send_word(input logic [15:0] d, input bit sw, input int drop_at);
    logic [15:0] exp_d;
    int          hi;
    int          exp_hi;
    exp_d   = swapw(d, sw);
    dl_wr   = 1'b1;
    dl_data = d;
    swap_en = sw;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    if (m_ovf) begin
      check_cnt++; if (mem_req !== m_req) $display("FAIL drop_req: got %b exp %b", mem_req, m_req); else pass_cnt++;
      check_cnt++; if (dl_wait !== 1'b0) $display("FAIL drop_wait: got %b exp 0", dl_wait); else pass_cnt++;
      check_cnt++; if (mem_data !== m_data) $display("FAIL drop_data: got %h exp %h", mem_data, m_data); else pass_cnt++;
      return;
    end
    m_req = ~m_req;
    m_data = exp_d;
    m_mem[int'(m_addr)] = exp_d;
    check_cnt++; if (mem_req !== m_req) $display("FAIL req_toggle: got %b exp %b", mem_req, m_req); else pass_cnt++;
    check_cnt++; if (mem_data !== exp_d) $display("FAIL data @%h: got %h exp %h", m_addr, mem_data, exp_d); else pass_cnt++;
    hi = 0;
    while (dl_wait === 1'b1 && hi < 200) begin
      hi++;
      if (hi == drop_at) dl_active = 1'b0;
      @(negedge clk_sys);
    end
    exp_hi = (dd_dly > sd_dly) ? dd_dly : sd_dly;
    check_cnt++; if (hi != exp_hi) $display("FAIL wait_len: got %0d exp %0d", hi, exp_hi); else pass_cnt++;
    if (m_addr == 24'hFFFFFE) m_ovf = 1'b1;
    else m_addr = m_addr + 24'd2;
    check_cnt++; if (mem_addr !== m_addr) $display("FAIL addr: got %h exp %h", mem_addr, m_addr); else pass_cnt++;
    check_cnt++; if (overflow !== m_ovf) $display("FAIL ovf: got %b exp %b", overflow, m_ovf); else pass_cnt++;
  endtask

  task automatic end_dl();
    dl_active = 1'b0;
    repeat (6) @(negedge clk_sys);
    check_cnt++; if (done_total - done_base != 1) $display("FAIL done_pulses: got %0d exp 1", done_total - done_base); else pass_cnt++;
    check_cnt++; if (mem_addr !== m_addr) $display("FAIL final_addr: got %h exp %h", mem_addr, m_addr); else pass_cnt++;
    check_cnt++; if (rom_size !== m_addr[23:16]) $display("FAIL rom_size: got %h exp %h", rom_size, m_addr[23:16]); else pass_cnt++;
    check_cnt++; if (hdr_present !== m_addr[9]) $display("FAIL hdr: got %b exp %b", hdr_present, m_addr[9]); else pass_cnt++;
    check_cnt++; if (populous !== model_pop(m_addr[9])) $display("FAIL populous: got %b exp %b", populous, model_pop(m_addr[9])); else pass_cnt++;
    check_cnt++; if (overflow !== m_ovf) $display("FAIL end_ovf: got %b exp %b", overflow, m_ovf); else pass_cnt++;
  endtask

  task automatic test_reset();
    check_cnt++; if (dl_wait !== 1'b0) $display("FAIL rst_wait: got %b exp 0", dl_wait); else pass_cnt++;
    check_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", mem_req); else pass_cnt++;
    check_cnt++; if (mem_addr !== 24'h0) $display("FAIL rst_addr: got %h exp 0", mem_addr); else pass_cnt++;
    check_cnt++; if (mem_data !== 16'h0) $display("FAIL rst_data: got %h exp 0", mem_data); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b exp 0", done); else pass_cnt++;
    check_cnt++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b exp 0", overflow); else pass_cnt++;
    check_cnt++; if (populous !== 1'b1) $display("FAIL rst_pop: got %b exp 1", populous); else pass_cnt++;
  endtask

  task automatic test_basic();
    start_dl(1'b0);
    dd_dly = 5; sd_dly = 5;
    send_word(16'h1234, 1'b0, -1);
    check_cnt++; if (mem_data !== 16'h1234) $display("FAIL basic_data: got %h exp 1234", mem_data); else pass_cnt++;
    check_cnt++; if (mem_addr !== 24'h2) $display("FAIL basic_addr: got %h exp 000002", mem_addr); else pass_cnt++;
    end_dl();
  endtask

  task automatic test_swap();
    start_dl(1'b0);
    dd_dly = 1; sd_dly = 1;
    send_word(16'h0180, 1'b1, -1);
    check_cnt++; if (mem_data !== 16'h8001) $display("FAIL swap_data: got %h exp 8001", mem_data); else pass_cnt++;
    end_dl();
  endtask

  task automatic test_split_ack();
    start_dl(1'b0);
    dd_dly = 3; sd_dly = 9;
    send_word(16'hA5C3, 1'b0, -1);
    end_dl();
  endtask

  task automatic test_fall_in_wait();
    start_dl(1'b0);
    dd_dly = 6; sd_dly = 4;
    send_word(16'($urandom), 1'b0, 2);
    end_dl();
  endtask

  task automatic test_rise_with_wr();
    start_dl(1'b1);
    dd_dly = 2; sd_dly = 1;
    send_word(16'h5A5A, 1'b1, -1);
    end_dl();
  endtask

  task automatic test_random();
    start_dl(1'b0);
    for (int i = 0; i < 40; i++) begin
      dd_dly = $urandom_range(1, 6);
      sd_dly = $urandom_range(1, 6);
      send_word(16'($urandom), 1'($urandom), -1);
    end
    end_dl();
  endtask

  task automatic test_reset_mid_wait();
    start_dl(1'b0);
    ack_hold = 1'b1;
    dl_wr = 1'b1; dl_data = 16'h7777; swap_en = 1'b0;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    check_cnt++; if (dl_wait !== 1'b1) $display("FAIL mid_wait_set: got %b exp 1", dl_wait); else pass_cnt++;
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check_cnt++; if (dl_wait !== 1'b0) $display("FAIL mid_rst_wait: got %b exp 0", dl_wait); else pass_cnt++;
    check_cnt++; if (mem_req !== 1'b0) $display("FAIL mid_rst_req: got %b exp 0", mem_req); else pass_cnt++;
    check_cnt++; if (mem_addr !== 24'h0) $display("FAIL mid_rst_addr: got %h exp 0", mem_addr); else pass_cnt++;
    m_req = 1'b0; m_data = 16'h0; m_addr = 24'h0;
    ack_clr = 1'b1;
    dl_active = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1; ack_clr = 1'b0; ack_hold = 1'b0;
    dl_wr = 1'b1; dl_data = 16'h1111;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    @(negedge clk_sys);
    check_cnt++; if (mem_req !== m_req) $display("FAIL idle_wr_req: got %b exp %b", mem_req, m_req); else pass_cnt++;
    check_cnt++; if (dl_wait !== 1'b0) $display("FAIL idle_wr_wait: got %b exp 0", dl_wait); else pass_cnt++;
  endtask

  task automatic test_headerless();
    logic [15:0] d;
    bit          sw;
    start_dl(1'b0);
    dd_dly = 1; sd_dly = 1;
    for (int i = 0; i < 'h2000; i++) begin
      d  = 16'($urandom);
      sw = 1'($urandom);
      case (2 * i)
        'h1F26: begin d = 16'h4F50; sw = 1'b0; end
        'h1F28: begin d = swapw(16'h5550, 1'b1); sw = 1'b1; end
        'h1F2A: begin d = 16'h4F4C; sw = 1'b0; end
        'h1F2C: begin d = 16'h5355; sw = 1'b0; end
        default: ;
      endcase
      send_word(d, sw, -1);
    end
    end_dl();
    check_cnt++; if (mem_addr !== 24'h004000) $display("FAIL nohdr_addr: got %h exp 004000", mem_addr); else pass_cnt++;
    check_cnt++; if (rom_size !== 8'h00) $display("FAIL nohdr_size: got %h exp 00", rom_size); else pass_cnt++;
    check_cnt++; if (hdr_present !== 1'b0) $display("FAIL nohdr_hdr: got %b exp 0", hdr_present); else pass_cnt++;
    check_cnt++; if (populous !== 1'b1) $display("FAIL nohdr_pop: got %b exp 1", populous); else pass_cnt++;
  endtask

  task automatic test_header();
    logic [15:0] d;
    start_dl(1'b0);
    dd_dly = 1; sd_dly = 1;
    for (int i = 0; i < 'h1100; i++) begin
      d = 16'($urandom);
      case (2 * i)
        'h2126: d = 16'h4F50;
        'h2128: d = 16'h0000;
        'h212A: d = 16'h4F4C;
        'h212C: d = 16'h5355;
        default: ;
      endcase
      send_word(d, 1'b0, -1);
    end
    end_dl();
    check_cnt++; if (hdr_present !== 1'b1) $display("FAIL hdr_hdr: got %b exp 1", hdr_present); else pass_cnt++;
    check_cnt++; if (populous !== 1'b0) $display("FAIL hdr_pop: got %b exp 0", populous); else pass_cnt++;
    check_cnt++; if (mem_addr !== 24'h002200) $display("FAIL hdr_addr: got %h exp 002200", mem_addr); else pass_cnt++;
  endtask

  task automatic test_overflow();
    start_dl(1'b0);
    dd_dly = 2; sd_dly = 1;
    force dut.addr_q = 24'hFFFFFE;
    @(negedge clk_sys);
    release dut.addr_q;
    m_addr = 24'hFFFFFE;
    send_word(16'hC0DE, 1'b0, -1);
    check_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b exp 1", overflow); else pass_cnt++;
    check_cnt++; if (mem_addr !== 24'hFFFFFE) $display("FAIL ovf_hold: got %h exp fffffe", mem_addr); else pass_cnt++;
    send_word(16'hDEAD, 1'b0, -1);
    end_dl();
    start_dl(1'b0);
    end_dl();
  endtask

  initial begin
    reset_n   = 1'b0;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_data   = 16'h0;
    swap_en   = 1'b0;
    ack_clr   = 1'b1;
    ack_hold  = 1'b0;
    dd_dly    = 1;
    sd_dly    = 1;
    m_req     = 1'b0;
    m_data    = 16'h0;
    m_addr    = 24'h0;
    m_ovf     = 1'b0;
    repeat (3) @(negedge clk_sys);
    test_reset();
    reset_n = 1'b1;
    ack_clr = 1'b0;
    @(negedge clk_sys);
    test_basic();
    test_swap();
    test_split_ack();
    test_fall_in_wait();
    test_rise_with_wr();
    test_random();
    test_reset_mid_wait();
    test_headerless();
    test_header();
    test_overflow();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
